// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, inverse SubBytes scheduler states and
// the MSB-first byte-select helper used across the decrypt path.
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_BYTES   = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } isb_state_e;

   // Byte 0 is the most significant byte of the state.
   function automatic logic [7:0] aes_byte(input logic [AES_STATE_W-1:0] s, input int i);
      return s[AES_STATE_W-1-8*i -: 8];
   endfunction

endpackage

// File: rtl/aes_inv_subbytes_sched_if.sv
// Valid/ready handshake bundle between the round controller, the inverse SubBytes
// scheduler and the downstream InvShiftRows/AddRoundKey stage.
interface aes_inv_subbytes_sched_if;
   import aes_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [AES_STATE_W-1:0] state_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [AES_STATE_W-1:0] state_isb;

   modport master (
      output in_valid, state_in, out_ready,
      input  in_ready, out_valid, state_isb
   );

   modport slave (
      input  in_valid, state_in, out_ready,
      output in_ready, out_valid, state_isb
   );

endinterface

// File: rtl/aes_inv_sbox_bram.sv
// Synchronous-read inverse S-box ROM; dout appears LAT clock edges after the
// address is presented.
module aes_inv_sbox_bram #(
   parameter int LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_addr,
   output logic [7:0] o_dout
);

   if (LAT < 1) begin : g_bad_lat
      $error("aes_inv_sbox_bram: LAT must be at least 1");
   end

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   logic [7:0] r_pipe [LAT];

   // NOTE: the table is a constant ROM and is never reset; only the read-data
   // registers take reset so dout comes out of reset at a known value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) r_pipe[k] <= '0;
      end else begin
         r_pipe[0] <= INV_SBOX[i_addr];
         for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end

   assign o_dout = r_pipe[LAT-1];

endmodule

// File: rtl/aes_inv_subbytes_sched.sv
// Time-multiplexed inverse SubBytes: streams 16 state bytes through NUM_SBOX shared
// inverse S-box lanes. Optional handshake counter under macro AES_ISB_BLKCNT_EN.
module aes_inv_subbytes_sched
   import aes_pkg::*;
#(
   parameter int NUM_SBOX = 4,
   parameter int SBOX_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   aes_inv_subbytes_sched_if.slave   bus,
   output logic                      busy
`ifdef AES_ISB_BLKCNT_EN
   ,
   output logic [31:0]               blk_count
`endif
);

   if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16))
   begin : g_bad_num_sbox
      $error("aes_inv_subbytes_sched: NUM_SBOX must be 1, 2, 4, 8 or 16");
   end
   if (SBOX_LAT < 1) begin : g_bad_sbox_lat
      $error("aes_inv_subbytes_sched: SBOX_LAT must be at least 1");
   end

   localparam int               G        = AES_BYTES / NUM_SBOX;
   localparam int               CNT_W    = (G > 1) ? $clog2(G) : 1;
   localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(G - 1);

   isb_state_e             r_state;
   isb_state_e             w_next_state;
   logic [AES_STATE_W-1:0] r_src;
   logic [AES_STATE_W-1:0] r_res;
   logic [CNT_W-1:0]       r_issue_cnt;
   logic [SBOX_LAT-1:0]    r_pipe_vld;
   logic [CNT_W-1:0]       r_pipe_grp [SBOX_LAT];
   logic [7:0]             w_addr [NUM_SBOX];
   logic [7:0]             w_dout [NUM_SBOX];
   logic                   w_accept;
   logic                   w_issue;
   logic                   w_release;
   logic                   w_last_return;
   logic                   w_rst_n;

   assign w_rst_n       = ~rst;
   assign w_accept      = (r_state == IDLE) && bus.in_valid;
   assign w_issue       = (r_state == ISSUE);
   assign w_release     = (r_state == DONE) && bus.out_ready;
   assign w_last_return = r_pipe_vld[SBOX_LAT-1] && (r_pipe_grp[SBOX_LAT-1] == LAST_GRP);

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.state_isb = r_res;
   assign busy          = (r_state != IDLE);

   // NOTE: next state gets its default before the case so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid)              w_next_state = ISSUE;
         ISSUE:   if (r_issue_cnt == LAST_GRP)   w_next_state = DRAIN;
         DRAIN:   if (w_last_return)             w_next_state = DONE;
         DONE:    if (bus.out_ready)             w_next_state = IDLE;
         default:                                w_next_state = IDLE;
      endcase
   end

   // Lane j of group issue_cnt reads byte issue_cnt*NUM_SBOX + j; lanes sit at 0 otherwise.
   always_comb begin
      for (int j = 0; j < NUM_SBOX; j++) begin
         w_addr[j] = '0;
         if (w_issue) w_addr[j] = aes_byte(r_src, int'(r_issue_cnt) * NUM_SBOX + j);
      end
   end

   for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
      aes_inv_sbox_bram #(
         .LAT (SBOX_LAT)
      ) u_sbox (
         .clk    (clk),
         .rst_n  (w_rst_n),
         .i_addr (w_addr[j]),
         .o_dout (w_dout[j])
      );
   end

   // NOTE: all state here uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_src       <= '0;
         r_res       <= '0;
         r_issue_cnt <= '0;
         r_pipe_vld  <= '0;
         for (int k = 0; k < SBOX_LAT; k++) r_pipe_grp[k] <= '0;
      end else begin
         r_state <= w_next_state;

         if (w_accept) begin
            r_src       <= bus.state_in;
            r_issue_cnt <= '0;
         end else if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
         end

         // Alignment pipe tracks which group each BRAM read belongs to.
         r_pipe_vld[0] <= w_issue;
         r_pipe_grp[0] <= r_issue_cnt;
         for (int k = 1; k < SBOX_LAT; k++) begin
            r_pipe_vld[k] <= r_pipe_vld[k-1];
            r_pipe_grp[k] <= r_pipe_grp[k-1];
         end

         if (r_pipe_vld[SBOX_LAT-1]) begin
            for (int j = 0; j < NUM_SBOX; j++) begin
               r_res[AES_STATE_W-1-8*(int'(r_pipe_grp[SBOX_LAT-1]) * NUM_SBOX + j) -: 8]
                  <= w_dout[j];
            end
         end
      end
   end

`ifdef AES_ISB_BLKCNT_EN
   logic [31:0] r_blk_count;

   always_ff @(posedge clk) begin
      if (rst)            r_blk_count <= '0;
      else if (w_release) r_blk_count <= r_blk_count + 32'd1;
   end

   assign blk_count = r_blk_count;
`else
   logic w_unused_release;
   assign w_unused_release = w_release;
`endif

endmodule

// File: tb/tb_aes_inv_subbytes_sched.sv
// Self-checking bench for aes_inv_subbytes_sched: GF(2^8)-based reference model,
// per-cycle compare on the default instance, directed cases and a parameter sweep.
module tb_aes_inv_subbytes_sched;

   localparam int LATENCY = 5;

   logic clk = 1'b0;
   logic rst;
   logic sw_rst;
   bit   sw_go;
   bit   sw_done [6];

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: inverse affine map followed by the GF(2^8) multiplicative inverse.
   logic [7:0] gf_inv [256];

   function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic       hi;
      a = a_in; b = b_in; p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   function automatic logic [7:0] ref_byte(input logic [7:0] x);
      return gf_inv[rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05];
   endfunction

   function automatic logic [127:0] ref_state(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = ref_byte(s[127-8*i -: 8]);
      return r;
   endfunction

   // Default-parameter instance.
   aes_inv_subbytes_sched_if mbus ();
   logic mbusy;
`ifdef AES_ISB_BLKCNT_EN
   logic [31:0] mblk;
`endif

   aes_inv_subbytes_sched u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (mbus),
      .busy      (mbusy)
`ifdef AES_ISB_BLKCNT_EN
      ,
      .blk_count (mblk)
`endif
   );

   // Transaction-level model: a block finishes LATENCY edges after acceptance.
   bit           m_live = 1'b0;
   bit           m_busy = 1'b0;
   int           m_cnt  = 0;
   logic [127:0] m_pend = '0;
   logic [127:0] m_res  = '0;
   logic [31:0]  m_blk  = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_live = 1'b1;
         m_busy = 1'b0;
         m_cnt  = 0;
         m_res  = '0;
         m_blk  = '0;
      end else if (!m_busy) begin
         if (mbus.in_valid) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_pend = ref_state(mbus.state_in);
         end
      end else if (m_cnt < LATENCY) begin
         m_cnt++;
         if (m_cnt == LATENCY) m_res = m_pend;
      end else if (mbus.out_ready) begin
         m_busy = 1'b0;
         m_blk  = m_blk + 32'd1;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("cyc_in_ready", mbus.in_ready, !m_busy);
         check("cyc_busy", mbusy, m_busy);
         check("cyc_out_valid", mbus.out_valid, m_busy && (m_cnt == LATENCY));
         if (!m_busy || m_cnt == LATENCY) check("cyc_state_isb", mbus.state_isb, m_res);
`ifdef AES_ISB_BLKCNT_EN
         check("cyc_blk_count", mblk, m_blk);
`endif
      end
   end

   // Sweep instances: NUM_SBOX {1,2,16} x SBOX_LAT {1,2}.
   for (genvar c = 0; c < 6; c++) begin : g_sweep
      localparam int SN = (c < 2) ? 1 : (c < 4) ? 2 : 16;
      localparam int SL = (c % 2) + 1;

      aes_inv_subbytes_sched_if sbus ();
      logic sbusy;
`ifdef AES_ISB_BLKCNT_EN
      logic [31:0] sblk;
`endif

      aes_inv_subbytes_sched #(
         .NUM_SBOX (SN),
         .SBOX_LAT (SL)
      ) u_dut (
         .clk       (clk),
         .rst       (sw_rst),
         .bus       (sbus),
         .busy      (sbusy)
`ifdef AES_ISB_BLKCNT_EN
         ,
         .blk_count (sblk)
`endif
      );

      initial begin
         logic [127:0] s;
         int           lat;
         sbus.in_valid  = 1'b0;
         sbus.state_in  = '0;
         sbus.out_ready = 1'b1;
         wait (sw_go);
         @(posedge clk); #1;
         for (int b = 0; b < 50; b++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            sbus.state_in = s;
            sbus.in_valid = 1'b1;
            @(posedge clk); #1;
            sbus.in_valid = 1'b0;
            lat = 0;
            while (!sbus.out_valid && lat < 64) begin
               @(posedge clk); #1;
               lat++;
            end
            check($sformatf("sweep_n%0d_l%0d_lat", SN, SL), lat, 16 / SN + SL);
            check($sformatf("sweep_n%0d_l%0d_res", SN, SL), sbus.state_isb, ref_state(s));
            @(posedge clk); #1;
         end
         sw_done[c] = 1'b1;
      end
   end

   // Starts and ends at #1 after an edge with the default instance idle.
   task automatic run_block(input string name, input logic [127:0] s, input logic [127:0] exp);
      int lat;
      int low;
      mbus.state_in  = s;
      mbus.in_valid  = 1'b1;
      mbus.out_ready = 1'b1;
      @(posedge clk); #1;
      mbus.in_valid = 1'b0;
      lat = 0;
      low = 0;
      if (!mbus.in_ready) low++;
      while (!mbus.out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
         if (!mbus.in_ready) low++;
      end
      check({name, "_lat"}, lat, LATENCY);
      check({name, "_res"}, mbus.state_isb, exp);
      @(posedge clk); #1;
      if (!mbus.in_ready) low++;
      check({name, "_ready_low"}, low, LATENCY + 1);
      check({name, "_valid_drop"}, mbus.out_valid, 1'b0);
   endtask

   initial begin
      logic [127:0] sa, sb, sc, sd;
      int           lat;
      int           ndone;

      rst            = 1'b1;
      sw_rst         = 1'b1;
      mbus.in_valid  = 1'b0;
      mbus.state_in  = '0;
      mbus.out_ready = 1'b1;

      gf_inv[0] = 8'h00;
      for (int x = 1; x < 256; x++) begin
         for (int y = 1; y < 256; y++) begin
            if (gf_mul(8'(x), 8'(y)) == 8'h01) gf_inv[x] = 8'(y);
         end
      end

      check("pin_00", ref_byte(8'h00), 8'h52);
      check("pin_01", ref_byte(8'h01), 8'h09);
      check("pin_7c", ref_byte(8'h7c), 8'h01);
      check("pin_16", ref_byte(8'h16), 8'hff);
      check("pin_63", ref_byte(8'h63), 8'h00);

      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      sw_rst = 1'b0;
      sw_go  = 1'b1;

      check("rst_in_ready", mbus.in_ready, 1'b1);
      check("rst_out_valid", mbus.out_valid, 1'b0);
      check("rst_busy", mbusy, 1'b0);
      check("rst_state_isb", mbus.state_isb, 128'h0);

      run_block("all63", {16{8'h63}}, 128'h0);
      run_block("order", 128'h00017c16_00000000_00000000_00000000,
                128'h520901ff_52525252_52525252_52525252);

      // Backpressure in DONE while upstream keeps offering new states.
      sa = 128'h0123456789abcdef_fedcba9876543210;
      mbus.state_in  = sa;
      mbus.in_valid  = 1'b1;
      mbus.out_ready = 1'b0;
      @(posedge clk); #1;
      mbus.in_valid = 1'b0;
      lat = 0;
      while (!mbus.out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_lat", lat, LATENCY);
      for (int k = 0; k < 10; k++) begin
         mbus.in_valid = ~mbus.in_valid;
         mbus.state_in = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         check("bp_hold_res", mbus.state_isb, ref_state(sa));
         check("bp_hold_in_ready", mbus.in_ready, 1'b0);
         check("bp_hold_out_valid", mbus.out_valid, 1'b1);
      end
      mbus.in_valid  = 1'b0;
      mbus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_busy", mbusy, 1'b0);
      check("bp_release_in_ready", mbus.in_ready, 1'b1);
      sb = 128'hdeadbeef_00112233_44556677_8899aabb;
      run_block("bp_next", sb, ref_state(sb));

      // Reset during the second ISSUE cycle.
      sc = 128'h3a5c_7e91_b2d4_f608_1a2b_3c4d_5e6f_7081;
      mbus.state_in = sc;
      mbus.in_valid = 1'b1;
      @(posedge clk); #1;
      mbus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_in_ready", mbus.in_ready, 1'b1);
      check("mid_rst_out_valid", mbus.out_valid, 1'b0);
      check("mid_rst_busy", mbusy, 1'b0);
      check("mid_rst_state_isb", mbus.state_isb, 128'h0);
      repeat (4) begin
         @(posedge clk); #1;
         check("mid_rst_no_stale", mbus.state_isb, 128'h0);
      end
      sd = 128'hc0ffee00_13579bdf_2468ace0_0f1e2d3c;
      run_block("post_rst", sd, ref_state(sd));

`ifdef AES_ISB_BLKCNT_EN
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      run_block("cnt_b0", sa, ref_state(sa));
      run_block("cnt_b1", sb, ref_state(sb));
      run_block("cnt_b2", sd, ref_state(sd));
      check("blk_count_3", mblk, 32'd3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("blk_count_rst", mblk, 32'd0);
`endif

      ndone = 0;
      for (int t = 0; t < 5000 && ndone < 6; t++) begin
         @(posedge clk);
         ndone = 0;
         for (int c = 0; c < 6; c++) if (sw_done[c]) ndone++;
      end
      check("sweep_complete", ndone, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
